// File: rtl/letter_scroller.sv
`default_nettype none
// ============================================================================
// Module      : letter_scroller
// Description : Scrolls a stored message of 5-bit letter codes across DIGITS
//               seven-segment positions. The message is followed by DIGITS
//               blank codes. Each output digit feeds one letter decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module letter_scroller #(
    parameter int         DIGITS     = 4,
    parameter int         MSG_DEPTH  = 16,
    parameter int         TICK_DIV   = 25000000,
    parameter logic [4:0] BLANK_CODE = 5'd31
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [4:0]                   wr_data,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         pause,
    output logic                         busy,
    output logic                         wrap_pulse,
    output logic [5*DIGITS-1:0]          digit_codes
);

    localparam int c_addr_w = $clog2(MSG_DEPTH);
    localparam int c_len_w  = c_addr_w + 1;
    localparam int c_off_w  = $clog2(MSG_DEPTH + DIGITS);
    // One extra bit so offset+k and the stream length never overflow.
    localparam int c_sum_w  = c_off_w + 1;
    localparam int c_cnt_w  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_pause = 2'd2;

    logic [1:0]          r_state,  w_state_nxt;
    logic [c_off_w-1:0]  r_offset, w_offset_nxt;
    logic [c_cnt_w-1:0]  r_count,  w_count_nxt;
    logic [c_len_w-1:0]  r_len,    w_len_nxt;
    logic                r_wrap,   w_wrap_nxt;
    logic [4:0]          r_buf [MSG_DEPTH];
    logic [5*DIGITS-1:0] r_digits, w_digits_nxt;

    logic [c_len_w-1:0]  w_len_clamped;
    logic [c_sum_w-1:0]  w_stream_len;
    logic                w_off_last;

    assign w_len_clamped = (msg_len > c_len_w'(MSG_DEPTH)) ? c_len_w'(MSG_DEPTH) : msg_len;
    assign w_stream_len  = c_sum_w'(r_len) + c_sum_w'(DIGITS);
    assign w_off_last    = (c_sum_w'(r_offset) == (w_stream_len - c_sum_w'(1)));

    assign busy        = (r_state != c_st_idle);
    assign wrap_pulse  = r_wrap;
    assign digit_codes = r_digits;

    // Control state register: state, scroll offset, tick count, latched length, wrap flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_offset <= '0;
            r_count  <= '0;
            r_len    <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_offset <= w_offset_nxt;
            r_count  <= w_count_nxt;
            r_len    <= w_len_nxt;
            r_wrap   <= w_wrap_nxt;
        end
    end

    // Next-state logic: stop beats start, start beats pause and ticking.
    always_comb begin
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_count_nxt  = r_count;
        w_len_nxt    = r_len;
        w_wrap_nxt   = 1'b0;
        if (stop) begin
            w_state_nxt  = c_st_idle;
            w_offset_nxt = '0;
            w_count_nxt  = '0;
        end else if (start && ((r_state != c_st_idle) || (msg_len != '0))) begin
            w_state_nxt  = c_st_run;
            w_offset_nxt = '0;
            w_count_nxt  = '0;
            w_len_nxt    = w_len_clamped;
        end else begin
            case (r_state)
                c_st_run: begin
                    if (pause) begin
                        // Entering PAUSE freezes the count where it is.
                        w_state_nxt = c_st_pause;
                    end else if (r_count == c_cnt_w'(TICK_DIV - 1)) begin
                        w_count_nxt = '0;
                        if (w_off_last) begin
                            w_offset_nxt = '0;
                            w_wrap_nxt   = 1'b1;
                        end else begin
                            w_offset_nxt = r_offset + c_off_w'(1);
                        end
                    end else begin
                        w_count_nxt = r_count + c_cnt_w'(1);
                    end
                end
                c_st_pause: begin
                    if (!pause) begin
                        w_state_nxt = c_st_run;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // Message buffer: cleared to blanks on reset, writable in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                r_buf[i] <= BLANK_CODE;
            end
        end else if (wr_en && (int'(wr_addr) < MSG_DEPTH)) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    // Window selection: position k (0 = leftmost) shows stream[(offset+k) mod S].
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [c_sum_w-1:0] w_sum;
        logic [c_sum_w-1:0] w_idx;
        assign w_sum = c_sum_w'(r_offset) + c_sum_w'(k);
        // offset < S and k < DIGITS <= S, so one subtraction wraps the index.
        assign w_idx = (w_sum >= w_stream_len) ? (w_sum - w_stream_len) : w_sum;
        assign w_digits_nxt[5*(DIGITS-1-k) +: 5] =
            ((r_state != c_st_idle) && (w_idx < c_sum_w'(r_len))) ? r_buf[w_idx[c_addr_w-1:0]]
                                                                   : BLANK_CODE;
    end

    // Registered digit outputs, one cycle behind state/offset/buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_digits <= {DIGITS{BLANK_CODE}};
        end else begin
            r_digits <= w_digits_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_letter_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_letter_scroller
// Description : Directed self-checking bench for letter_scroller with
//               TICK_DIV=4, DIGITS=4, MSG_DEPTH=16, BLANK_CODE=31.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_letter_scroller;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [4:0]  wr_data;
    logic [4:0]  msg_len;
    logic        start;
    logic        stop;
    logic        pause;
    logic        busy;
    logic        wrap_pulse;
    logic [19:0] digit_codes;

    int checks   = 0;
    int failures = 0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    letter_scroller #(
        .DIGITS    (4),
        .MSG_DEPTH (16),
        .TICK_DIV  (4),
        .BLANK_CODE(5'd31)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .msg_len    (msg_len),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .busy       (busy),
        .wrap_pulse (wrap_pulse),
        .digit_codes(digit_codes)
    );

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pack a window, leftmost digit first.
    function automatic logic [19:0] win(input int a, input int b, input int c, input int d);
        return {5'(a), 5'(b), 5'(c), 5'(d)};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy actual=%b required=0", busy);
        end
        checks++;
        if (wrap_pulse !== 1'b0) begin
            failures++; $display("FAIL reset_wrap actual=%b required=0", wrap_pulse);
        end
        checks++;
        if (digit_codes !== win(31, 31, 31, 31)) begin
            failures++; $display("FAIL reset_digits actual=%h required=%h", digit_codes, win(31, 31, 31, 31));
        end
        reset   = 1'b0;
        msg_len = 5'd0;
        start   = 1'b1;
        step(1);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL zero_len_start_busy actual=%b required=0", busy);
        end
        step(1);
        checks++;
        if (digit_codes !== win(31, 31, 31, 31)) begin
            failures++; $display("FAIL zero_len_start_digits actual=%h required=%h", digit_codes, win(31, 31, 31, 31));
        end
    endtask

    task automatic test_scroll();
        int msg [5] = '{7, 4, 11, 11, 14};
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = 5'(msg[i]);
            step(1);
        end
        wr_en   = 1'b0;
        msg_len = 5'd5;
        start   = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL scroll_busy actual=%b required=1", busy);
        end
        checks++;
        if (digit_codes !== win(7, 4, 11, 11)) begin
            failures++; $display("FAIL scroll_offset0 actual=%h required=%h", digit_codes, win(7, 4, 11, 11));
        end
        step(4);
        checks++;
        if (digit_codes !== win(4, 11, 11, 14)) begin
            failures++; $display("FAIL scroll_offset1 actual=%h required=%h", digit_codes, win(4, 11, 11, 14));
        end
        step(4);
        checks++;
        if (digit_codes !== win(11, 11, 14, 31)) begin
            failures++; $display("FAIL scroll_offset2 actual=%h required=%h", digit_codes, win(11, 11, 14, 31));
        end
    endtask

    task automatic test_wrap();
        step(26);
        checks++;
        if (wrap_pulse !== 1'b0) begin
            failures++; $display("FAIL wrap_early actual=%b required=0", wrap_pulse);
        end
        step(1);
        checks++;
        if (wrap_pulse !== 1'b1) begin
            failures++; $display("FAIL wrap_pulse actual=%b required=1", wrap_pulse);
        end
        checks++;
        if (digit_codes !== win(31, 7, 4, 11)) begin
            failures++; $display("FAIL wrap_last_window actual=%h required=%h", digit_codes, win(31, 7, 4, 11));
        end
        step(1);
        checks++;
        if (wrap_pulse !== 1'b0) begin
            failures++; $display("FAIL wrap_width actual=%b required=0", wrap_pulse);
        end
        checks++;
        if (digit_codes !== win(7, 4, 11, 11)) begin
            failures++; $display("FAIL wrap_window actual=%h required=%h", digit_codes, win(7, 4, 11, 11));
        end
    endtask

    task automatic test_pause();
        step(1);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if (digit_codes !== win(7, 4, 11, 11) || busy !== 1'b1 || wrap_pulse !== 1'b0) begin
                failures++;
                $display("FAIL pause_hold[%0d] actual=%h/%b/%b required=%h/1/0", i, digit_codes, busy, wrap_pulse, win(7, 4, 11, 11));
            end
        end
        pause = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if (digit_codes !== win(7, 4, 11, 11)) begin
                failures++; $display("FAIL pause_resume_hold[%0d] actual=%h required=%h", i, digit_codes, win(7, 4, 11, 11));
            end
        end
        step(1);
        checks++;
        if (digit_codes !== win(4, 11, 11, 14)) begin
            failures++; $display("FAIL pause_resume_advance actual=%h required=%h", digit_codes, win(4, 11, 11, 14));
        end
    endtask

    task automatic test_stop_start();
        stop  = 1'b1;
        start = 1'b1;
        step(1);
        stop  = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL stop_priority_busy actual=%b required=0", busy);
        end
        step(1);
        checks++;
        if (digit_codes !== win(31, 31, 31, 31)) begin
            failures++; $display("FAIL stop_blank actual=%h required=%h", digit_codes, win(31, 31, 31, 31));
        end
        wr_en   = 1'b1;
        wr_addr = 4'd15;
        wr_data = 5'd9;
        step(1);
        wr_en   = 1'b0;
        msg_len = 5'd20;
        start   = 1'b1;
        step(1);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL clamp_busy actual=%b required=1", busy);
        end
        step(1);
        checks++;
        if (digit_codes !== win(7, 4, 11, 11)) begin
            failures++; $display("FAIL clamp_offset0 actual=%h required=%h", digit_codes, win(7, 4, 11, 11));
        end
        step(60);
        checks++;
        if (digit_codes !== win(9, 31, 31, 31)) begin
            failures++; $display("FAIL clamp_offset15 actual=%h required=%h", digit_codes, win(9, 31, 31, 31));
        end
        step(16);
        checks++;
        if (digit_codes !== win(31, 7, 4, 11)) begin
            failures++; $display("FAIL clamp_offset19 actual=%h required=%h", digit_codes, win(31, 7, 4, 11));
        end
        step(2);
        checks++;
        if (wrap_pulse !== 1'b0) begin
            failures++; $display("FAIL clamp_wrap_early actual=%b required=0", wrap_pulse);
        end
        step(1);
        checks++;
        if (wrap_pulse !== 1'b1) begin
            failures++; $display("FAIL clamp_wrap actual=%b required=1", wrap_pulse);
        end
    endtask

    task automatic test_write_and_reset();
        logic [4:0] lead;
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 5'd3;
        step(1);
        wr_en = 1'b0;
        lead  = digit_codes[19:15];
        checks++;
        if (lead !== 5'd7) begin
            failures++; $display("FAIL run_write_early actual=%0d required=7", lead);
        end
        step(1);
        checks++;
        if (digit_codes !== win(3, 4, 11, 11)) begin
            failures++; $display("FAIL run_write_visible actual=%h required=%h", digit_codes, win(3, 4, 11, 11));
        end
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = 5'd5;
        step(1);
        reset = 1'b0;
        wr_en = 1'b0;
        checks++;
        if (busy !== 1'b0 || wrap_pulse !== 1'b0 || digit_codes !== win(31, 31, 31, 31)) begin
            failures++;
            $display("FAIL midrun_reset actual=%b/%b/%h required=0/0/%h", busy, wrap_pulse, digit_codes, win(31, 31, 31, 31));
        end
        msg_len = 5'd2;
        start   = 1'b1;
        step(1);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL post_reset_busy actual=%b required=1", busy);
        end
        step(1);
        checks++;
        if (digit_codes !== win(31, 31, 31, 31)) begin
            failures++; $display("FAIL buffer_cleared actual=%h required=%h", digit_codes, win(31, 31, 31, 31));
        end
    endtask

    // Scenario sequence; each task continues from where the previous one left off.
    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 4'd0;
        wr_data = 5'd0;
        msg_len = 5'd0;
        start   = 1'b0;
        stop    = 1'b0;
        pause   = 1'b0;
        test_reset();
        test_scroll();
        test_wrap();
        test_pause();
        test_stop_start();
        test_write_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
